// File: rtl/sub_bytes_engine_if.sv
// rtl/sub_bytes_engine_if.sv - block-in / result-out handshake bundle for sub_bytes_engine
// inv_mode exists only when SUB_BYTES_INV_EN is defined.
interface sub_bytes_engine_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
`ifdef SUB_BYTES_INV_EN
   logic         inv_mode;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;

   modport master (
`ifdef SUB_BYTES_INV_EN
      output inv_mode,
`endif
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
`ifdef SUB_BYTES_INV_EN
      input  inv_mode,
`endif
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/sub_bytes_engine.sv
// rtl/sub_bytes_engine.sv - multi-cycle AES SubBytes, LANES S-box lookups per cycle
// SUB_BYTES_INV_EN adds the inverse S-box and per-block inv_mode selection.
module sub_bytes_engine #(
   parameter int LANES = 4
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               clear,
   sub_bytes_engine_if.slave  bus
);

   if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_check
      $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
   end

   localparam logic [3:0] STEP = 4'(LANES);
   localparam logic [3:0] LAST = 4'(16 - LANES);

   // Entry b sits at bits [(255-b)*8 +: 8], i.e. offset {~b, 3'b000}.
   localparam logic [2047:0] SBOX_FWD = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
      return SBOX_FWD[{~b, 3'b000} +: 8];
   endfunction

`ifdef SUB_BYTES_INV_EN
   localparam logic [2047:0] SBOX_INV = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] sbox_inv(input logic [7:0] b);
      return SBOX_INV[{~b, 3'b000} +: 8];
   endfunction
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_SUB,
      S_DONE
   } state_t;

   state_t       state_q, state_d;
   logic [3:0]   idx_q, idx_d;
   logic [127:0] data_q, data_d;
   logic [3:0]   byte_i;
`ifdef SUB_BYTES_INV_EN
   logic         mode_q, mode_d;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;
      byte_i  = 4'd0;
`ifdef SUB_BYTES_INV_EN
      mode_d  = mode_q;
`endif
      // Abort keeps the working register as-is so a partial result stays visible.
      if (clear) begin
         state_d = S_IDLE;
         idx_d   = 4'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.in_valid) begin
                  data_d  = bus.in_data;
                  idx_d   = 4'd0;
                  state_d = S_SUB;
`ifdef SUB_BYTES_INV_EN
                  mode_d  = bus.inv_mode;
`endif
               end
            end
            S_SUB: begin
               // Byte 0 is the MSB, so byte i lives at bit offset {~i, 3'b000}.
               for (int l = 0; l < LANES; l++) begin
                  byte_i = idx_q + 4'(l);
`ifdef SUB_BYTES_INV_EN
                  data_d[{~byte_i, 3'b000} +: 8] = mode_q ? sbox_inv(data_q[{~byte_i, 3'b000} +: 8])
                                                          : sbox_fwd(data_q[{~byte_i, 3'b000} +: 8]);
`else
                  data_d[{~byte_i, 3'b000} +: 8] = sbox_fwd(data_q[{~byte_i, 3'b000} +: 8]);
`endif
               end
               idx_d = idx_q + STEP;
               if (idx_q == LAST) begin
                  state_d = S_DONE;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= S_IDLE;
         idx_q   <= 4'd0;
         data_q  <= '0;
`ifdef SUB_BYTES_INV_EN
         mode_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
`ifdef SUB_BYTES_INV_EN
         mode_q  <= mode_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.busy      = (state_q == S_SUB) || (state_q == S_DONE);
   assign bus.out_data  = data_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// tb/tb_sub_bytes_engine.sv - directed bench running LANES = 4, 1, 2, 8, 16 engines side by side
// Instance 0 (LANES=4) carries the handshake, abort and reset scenarios.
module tb_sub_bytes_engine;

   localparam int NI = 5;
   localparam int LN  [NI] = '{4, 1, 2, 8, 16};
   localparam int LAT [NI] = '{4, 16, 8, 2, 1};

   localparam logic [127:0] VEC_IN  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] VEC_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;
   localparam logic [127:0] VEC_PART = 128'h638293c3445566778899aabbccddeeff;
   localparam logic [127:0] ALL_FF  = {16{8'hff}};
   localparam logic [127:0] ALL_16  = {16{8'h16}};

   logic         clk = 1'b0;
   logic         n_rst;
   logic         clear;
   logic         in_valid;
   logic         out_ready;
   logic [127:0] in_data;
`ifdef SUB_BYTES_INV_EN
   logic         inv_mode;
`endif

   logic [NI-1:0] ir, ov, bz;
   logic [127:0]  od [NI];

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      sub_bytes_engine_if bus ();
      assign bus.in_valid  = in_valid;
      assign bus.in_data   = in_data;
      assign bus.out_ready = out_ready;
`ifdef SUB_BYTES_INV_EN
      assign bus.inv_mode  = inv_mode;
`endif
      sub_bytes_engine #(.LANES(LN[g])) dut (
         .clk   (clk),
         .n_rst (n_rst),
         .clear (clear),
         .bus   (bus)
      );
      assign ir[g] = bus.in_ready;
      assign ov[g] = bus.out_valid;
      assign bz[g] = bus.busy;
      assign od[g] = bus.out_data;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (20) tick();
   endtask

   task automatic test_reset();
      n_rst     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_data   = '0;
`ifdef SUB_BYTES_INV_EN
      inv_mode  = 1'b0;
`endif
      repeat (3) tick();
      for (int g = 0; g < NI; g++) begin
         vectors += 4;
         if (ir[g] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d] got %b want 1", g, ir[g]); end
         if (ov[g] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d] got %b want 0", g, ov[g]); end
         if (bz[g] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got %b want 0", g, bz[g]); end
         if (od[g] !== 128'h0) begin errors++; $display("FAIL reset_out_data[%0d] got %h want 0", g, od[g]); end
      end
      n_rst = 1'b1;
      tick();
   endtask

   task automatic test_latency_sweep();
      int lat [NI];
      for (int g = 0; g < NI; g++) lat[g] = -1;
      out_ready = 1'b1;
      in_data   = VEC_IN;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      in_data   = '0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 1) begin
            vectors += 2;
            if (bz[0] !== 1'b1) begin errors++; $display("FAIL sweep_busy got %b want 1", bz[0]); end
            if (ir[0] !== 1'b0) begin errors++; $display("FAIL sweep_in_ready got %b want 0", ir[0]); end
         end
         for (int g = 0; g < NI; g++) begin
            if (ov[g] === 1'b1 && lat[g] < 0) begin
               lat[g] = c;
               vectors++;
               if (od[g] !== VEC_OUT) begin
                  errors++;
                  $display("FAIL sweep_data[LANES=%0d] got %h want %h", LN[g], od[g], VEC_OUT);
               end
            end
         end
      end
      for (int g = 0; g < NI; g++) begin
         vectors++;
         if (lat[g] != LAT[g]) begin
            errors++;
            $display("FAIL sweep_latency[LANES=%0d] got %0d want %0d", LN[g], lat[g], LAT[g]);
         end
      end
   endtask

   task automatic test_backpressure();
      int n;
      out_ready = 1'b0;
      in_data   = VEC_IN;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      n = 0;
      while (ov[0] !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      vectors++;
      if (n != 4) begin errors++; $display("FAIL bp_latency got %0d want 4", n); end
      in_data  = ALL_FF;
      in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         vectors += 3;
         if (ov[0] !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc %0d got %b want 1", c, ov[0]); end
         if (od[0] !== VEC_OUT) begin errors++; $display("FAIL bp_hold_data cyc %0d got %h want %h", c, od[0], VEC_OUT); end
         if (ir[0] !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready cyc %0d got %b want 0", c, ir[0]); end
      end
      out_ready = 1'b1;
      tick();
      vectors += 3;
      if (ir[0] !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", ir[0]); end
      if (ov[0] !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b want 0", ov[0]); end
      if (bz[0] !== 1'b0) begin errors++; $display("FAIL bp_release_busy got %b want 0", bz[0]); end
      tick();
      in_valid = 1'b0;
      vectors += 2;
      if (bz[0] !== 1'b1) begin errors++; $display("FAIL bp_accept_busy got %b want 1", bz[0]); end
      if (ir[0] !== 1'b0) begin errors++; $display("FAIL bp_accept_in_ready got %b want 0", ir[0]); end
      n = 0;
      while (ov[0] !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      vectors++;
      if (ov[0] !== 1'b1 || od[0] !== ALL_16) begin
         errors++;
         $display("FAIL bp_second_block valid %b data %h want 1 %h", ov[0], od[0], ALL_16);
      end
      drain();
   endtask

   task automatic test_abort();
      bit seen;
      bit got [NI];
      out_ready = 1'b1;
      in_data   = VEC_IN;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      vectors += 4;
      if (ir[0] !== 1'b1) begin errors++; $display("FAIL abort_in_ready got %b want 1", ir[0]); end
      if (bz[0] !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bz[0]); end
      if (ov[0] !== 1'b0) begin errors++; $display("FAIL abort_out_valid got %b want 0", ov[0]); end
      if (od[0] !== VEC_PART) begin errors++; $display("FAIL abort_partial got %h want %h", od[0], VEC_PART); end
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (ov[0] === 1'b1) seen = 1'b1;
      end
      vectors++;
      if (seen) begin errors++; $display("FAIL abort_no_valid got 1 want 0"); end
      in_data  = VEC_IN;
      in_valid = 1'b1;
      clear    = 1'b1;
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      for (int g = 0; g < NI; g++) begin
         vectors++;
         if (bz[g] !== 1'b0) begin errors++; $display("FAIL clear_blocks_accept[LANES=%0d] got %b want 0", LN[g], bz[g]); end
      end
      in_data  = ALL_FF;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int g = 0; g < NI; g++) got[g] = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         for (int g = 0; g < NI; g++) begin
            if (ov[g] === 1'b1 && !got[g]) begin
               got[g] = 1'b1;
               vectors++;
               if (od[g] !== ALL_16) begin
                  errors++;
                  $display("FAIL abort_ff_block[LANES=%0d] got %h want %h", LN[g], od[g], ALL_16);
               end
            end
         end
      end
      for (int g = 0; g < NI; g++) begin
         vectors++;
         if (!got[g]) begin errors++; $display("FAIL abort_ff_timeout[LANES=%0d] got no out_valid", LN[g]); end
      end
   endtask

   task automatic test_async_reset();
      int n;
      out_ready = 1'b1;
      in_data   = VEC_IN;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      tick();
      tick();
      vectors++;
      if (bz[0] !== 1'b1) begin errors++; $display("FAIL areset_pre_busy got %b want 1", bz[0]); end
      #2;
      n_rst = 1'b0;
      #1;
      vectors += 4;
      if (od[0] !== 128'h0) begin errors++; $display("FAIL areset_out_data got %h want 0", od[0]); end
      if (bz[0] !== 1'b0) begin errors++; $display("FAIL areset_busy got %b want 0", bz[0]); end
      if (ir[0] !== 1'b1) begin errors++; $display("FAIL areset_in_ready got %b want 1", ir[0]); end
      if (od[1] !== 128'h0) begin errors++; $display("FAIL areset_out_data_l1 got %h want 0", od[1]); end
      #2;
      n_rst    = 1'b1;
      in_data  = ALL_FF;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      vectors++;
      if (bz[0] !== 1'b1) begin errors++; $display("FAIL areset_first_accept got %b want 1", bz[0]); end
      n = 0;
      while (ov[0] !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      vectors++;
      if (ov[0] !== 1'b1 || od[0] !== ALL_16) begin
         errors++;
         $display("FAIL areset_block valid %b data %h want 1 %h", ov[0], od[0], ALL_16);
      end
      drain();
   endtask

`ifdef SUB_BYTES_INV_EN
   task automatic test_inverse();
      int n;
      out_ready = 1'b1;
      in_data   = VEC_OUT;
      inv_mode  = 1'b1;
      in_valid  = 1'b1;
      tick();
      inv_mode  = 1'b0;
      in_valid  = 1'b0;
      n = 0;
      while (ov[0] !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      vectors++;
      if (ov[0] !== 1'b1 || od[0] !== VEC_IN) begin
         errors++;
         $display("FAIL inverse valid %b data %h want 1 %h", ov[0], od[0], VEC_IN);
      end
      drain();
      in_data  = VEC_IN;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (ov[0] !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      vectors++;
      if (ov[0] !== 1'b1 || od[0] !== VEC_OUT) begin
         errors++;
         $display("FAIL inverse_then_forward valid %b data %h want 1 %h", ov[0], od[0], VEC_OUT);
      end
      drain();
   endtask
`endif

   initial begin
      test_reset();
      test_latency_sweep();
      drain();
      test_backpressure();
      test_abort();
      drain();
      test_async_reset();
`ifdef SUB_BYTES_INV_EN
      test_inverse();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
